serial_frame_rx: RTL and testbench

//  Receiving end of the single-wire synchronous serial link whose launch side is a registered

---
 rtl/serial_link_pkg.sv | 23 ++
 rtl/serial_frame_rx_if.sv | 22 ++
 rtl/serial_shift_reg.sv | 33 +++
 rtl/serial_frame_rx.sv | 139 +++++++++++++
 tb/tb_serial_frame_rx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-wire synchronous serial link (receiver and transmitter).
package serial_link_pkg;

    localparam int unsigned MAX_DATA_W = 16;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } rx_state_e;

    // Even-parity bit for up to MAX_DATA_W payload bits (zero-extend narrower words).
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial line plus word-side valid/ack handshake and error flags of the frame receiver.
interface serial_frame_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              din;
    logic              rd_ack;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;

    modport master (
        output din, rd_ack,
        input  data, data_valid, parity_err, frame_err, overrun
    );

    modport slave (
        input  din, rd_ack,
        output data, data_valid, parity_err, frame_err, overrun
    );
endinterface

// File: rtl/serial_shift_reg.sv
// Right-shift register: new bits enter at the MSB so an LSB-first stream lands in order.
module serial_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sr_q;

    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (shift_en) begin
            sr_d = {din, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q;
endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: deframes start/data/parity/stop, checks errors and holds each good
// word behind a valid/ack handshake with sticky overrun.
module serial_frame_rx
    import serial_link_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_frame_rx_if.slave  rx
);
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e         state_d, state_q;
    logic [CNT_W-1:0]  bit_cnt_d, bit_cnt_q;
    logic              din_q;
    logic              par_bit_d, par_bit_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic              data_valid_d, data_valid_q;
    logic              parity_err_d, parity_err_q;
    logic              frame_err_d, frame_err_q;
    logic              overrun_d, overrun_q;
    logic              sr_clr, sr_shift, accept, par_bad;
    logic [DATA_W-1:0] sr;

    serial_shift_reg #(.WIDTH(DATA_W)) u_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sr_clr),
        .shift_en (sr_shift),
        .din      (din_q),
        .q        (sr)
    );

    assign par_bad = PARITY_EN && (even_parity(MAX_DATA_W'(sr)) ^ par_bit_q);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        par_bit_d    = par_bit_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        sr_clr       = 1'b0;
        sr_shift     = 1'b0;
        accept       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (din_q == START_BIT) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    sr_clr    = 1'b1;
                end
            end
            DATA: begin
                sr_shift = 1'b1;
                // Counter holds on the last bit so it never wraps inside a frame.
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = PARITY_EN ? PARITY : STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                par_bit_d = din_q;
                state_d   = STOP;
            end
            STOP: begin
                if (din_q != STOP_BIT) begin
                    frame_err_d = 1'b1;
                    state_d     = BREAK;
                end else if (par_bad) begin
                    parity_err_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            BREAK: begin
                if (din_q == IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Word-side handshake: an ack in the accept cycle frees the slot for the new word.
        if (accept) begin
            if (!data_valid_q || rx.rd_ack) begin
                data_d       = sr;
                data_valid_d = 1'b1;
                if (rx.rd_ack) begin
                    overrun_d = 1'b0;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx.rd_ack && data_valid_q) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q        <= IDLE_LEVEL;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            par_bit_q    <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            din_q        <= rx.din;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            par_bit_q    <= par_bit_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx.data       = data_q;
    assign rx.data_valid = data_valid_q;
    assign rx.parity_err = parity_err_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.overrun    = overrun_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx (DATA_W=8, PARITY_EN=1).
module tb_serial_frame_rx;
    import serial_link_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   perr_cnt = 0;
    int   ferr_cnt = 0;

    serial_frame_rx_if #(.DATA_W(8)) bus ();

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus)
    );

    always #5 clk = ~clk;

    // Count error-pulse cycles just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.parity_err) perr_cnt++;
        if (bus.frame_err)  ferr_cnt++;
    end

    task automatic send_bit(input logic b);
        bus.din = b;
        @(negedge clk);
    endtask

    // Drives one frame; returns one negedge after the stop bit was applied (din still = stop).
    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop,
                              input int ack_at);
        logic [10:0] bits;
        bits = {stop, (^d) ^ flip_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.rd_ack = (i == ack_at);
            send_bit(bits[i]);
        end
        bus.rd_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.din = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
    endtask

    task automatic check_word(input string name, input logic [7:0] exp_data,
                              input logic exp_valid, input logic exp_ovr);
        n_cmp++;
        if (bus.data !== exp_data) begin
            n_err++;
            $display("FAIL %s data: got %h want %h", name, bus.data, exp_data);
        end
        n_cmp++;
        if (bus.data_valid !== exp_valid) begin
            n_err++;
            $display("FAIL %s data_valid: got %b want %b", name, bus.data_valid, exp_valid);
        end
        n_cmp++;
        if (bus.overrun !== exp_ovr) begin
            n_err++;
            $display("FAIL %s overrun: got %b want %b", name, bus.overrun, exp_ovr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) send_bit(i[0]);
        check_word("reset", 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset err flags: got %b%b want 00", bus.parity_err, bus.frame_err);
        end
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_err++;
            $display("FAIL reset state: got %0d want %0d", dut.state_q, IDLE);
        end
        bus.din = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_good_frame();
        int p0, f0;
        p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        bus.din = 1'b1;
        n_cmp++;
        if (bus.data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL good latency early valid: got %b want 0", bus.data_valid);
        end
        @(negedge clk);
        check_word("good A5", 8'hA5, 1'b1, 1'b0);
        idle(3);
        n_cmp++;
        if (perr_cnt != p0 || ferr_cnt != f0) begin
            n_err++;
            $display("FAIL good err pulses: got %0d/%0d want 0/0", perr_cnt - p0, ferr_cnt - f0);
        end
        ack_pulse();
        check_word("good ack", 8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_parity_err();
        int p0;
        p0 = perr_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        idle(4);
        n_cmp++;
        if (perr_cnt - p0 != 1) begin
            n_err++;
            $display("FAIL parity pulse cycles: got %0d want 1", perr_cnt - p0);
        end
        check_word("parity discard", 8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = ferr_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, -1);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        idle(3);
        n_cmp++;
        if (ferr_cnt - f0 != 1) begin
            n_err++;
            $display("FAIL frame_err pulse cycles: got %0d want 1", ferr_cnt - f0);
        end
        check_word("frame_err discard", 8'hA5, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, -1);
        idle(2);
        check_word("after break 81", 8'h81, 1'b1, 1'b0);
        ack_pulse();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b0, 1'b1, -1);
        idle(2);
        send_frame(8'h22, 1'b0, 1'b1, -1);
        idle(2);
        check_word("overrun", 8'h11, 1'b1, 1'b1);
        ack_pulse();
        check_word("overrun ack", 8'h11, 1'b0, 1'b0);
    endtask

    task automatic test_ack_same_cycle();
        send_frame(8'h33, 1'b0, 1'b1, -1);
        idle(2);
        check_word("pre 33", 8'h33, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, -1);
        bus.din = 1'b1;
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        check_word("ack+accept 55", 8'h55, 1'b1, 1'b0);
        @(negedge clk);
        check_word("ack+accept hold", 8'h55, 1'b1, 1'b0);
        ack_pulse();
    endtask

    task automatic test_back_to_back();
        int p0, f0;
        p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h12, 1'b0, 1'b1, -1);
        send_frame(8'h34, 1'b0, 1'b1, 2);
        idle(1);
        check_word("back-to-back 34", 8'h34, 1'b1, 1'b0);
        n_cmp++;
        if (perr_cnt != p0 || ferr_cnt != f0) begin
            n_err++;
            $display("FAIL b2b err pulses: got %0d/%0d want 0/0", perr_cnt - p0, ferr_cnt - f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        bus.din = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_word("mid reset", 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_err++;
            $display("FAIL mid reset state: got %0d want %0d", dut.state_q, IDLE);
        end
        idle(2);
        send_frame(8'h96, 1'b0, 1'b1, -1);
        idle(2);
        check_word("after reset 96", 8'h96, 1'b1, 1'b0);
    endtask

    initial begin
        bus.din = 1'b1;
        bus.rd_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_overrun();
        test_ack_same_cycle();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
